// File: rtl/lii_stream_downsizer.sv
// lii_stream_downsizer: splits each wide LII beat into RATIO narrow slices, LSB slice first, with no bubbles between beats.
// Ports:
//   aclk, arstn              clock, asynchronous active-low reset
//   lii_in_p0_tdata/tvalid/tready, lii_in_p0_src/dst   wide input beat and routing tags
//   out_stream_tdata/tvalid/tready/tlast, out_src/out_dst   narrow slice stream and held tags
//   beat_cnt                 wide beats accepted since reset, saturating
module lii_stream_downsizer #(
   parameter int PW = 1024,
   parameter int OW = 256
) (
   input  logic          aclk,
   input  logic          arstn,
   input  logic [PW-1:0] lii_in_p0_tdata,
   input  logic          lii_in_p0_tvalid,
   output logic          lii_in_p0_tready,
   input  logic [7:0]    lii_in_p0_src,
   input  logic [7:0]    lii_in_p0_dst,
   output logic [OW-1:0] out_stream_tdata,
   output logic          out_stream_tvalid,
   input  logic          out_stream_tready,
   output logic          out_stream_tlast,
   output logic [7:0]    out_src,
   output logic [7:0]    out_dst,
   output logic [31:0]   beat_cnt
);
   localparam int RATIO = PW / OW;
   localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
   if (RATIO < 2 || PW % OW != 0) begin : g_bad_ratio
      $error("lii_stream_downsizer: PW must be a multiple of OW with PW/OW >= 2");
   end
   typedef enum logic {IDLE, SEND} state_t;
   state_t                   state_q, state_d;
   logic [RATIO-1:0][OW-1:0] buf_q, buf_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [7:0]               src_q, src_d, dst_q, dst_d;
   logic [31:0]              cnt_q, cnt_d;
   logic                     last, in_hs, out_hs;
   assign last              = idx_q == IW'(RATIO - 1);
   assign out_hs            = (state_q == SEND) & out_stream_tready;
   // A new beat may load in the same cycle the last slice of the current beat leaves.
   assign lii_in_p0_tready  = (state_q == IDLE) | (out_stream_tready & last);
   assign in_hs             = lii_in_p0_tvalid & lii_in_p0_tready;
   assign out_stream_tvalid = state_q == SEND;
   assign out_stream_tdata  = buf_q[idx_q];
   assign out_stream_tlast  = (state_q == SEND) & last;
   assign out_src           = src_q;
   assign out_dst           = dst_q;
   assign beat_cnt          = cnt_q;
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      if (in_hs) begin
         state_d = SEND;
         buf_d   = lii_in_p0_tdata;
         idx_d   = '0;
         src_d   = lii_in_p0_src;
         dst_d   = lii_in_p0_dst;
         cnt_d   = &cnt_q ? cnt_q : cnt_q + 32'd1;
      end else if (out_hs) begin
         state_d = last ? IDLE : SEND;
         idx_d   = last ? '0 : idx_q + IW'(1);
      end
   end
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q <= IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
